// File: rtl/lfsr_seq_gen.sv
// lfsr_seq_gen: runs a configurable LFSR for a requested number of steps,
// streaming each new value with a valid strobe and pulsing done at the end.
// Optional feature macro: LFSR_GALOIS_MODE_EN enables Galois stepping
// (selected per run by mode); without it every run uses Fibonacci stepping.
module lfsr_seq_gen #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic [WIDTH-1:0] taps,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] seq_num,
  input  logic             mode,
  output logic [WIDTH-1:0] num,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] taps_q;
  logic [WIDTH-1:0] seed_q;
  logic [CNT_W-1:0] seq_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] step_next;

  // Counter never exceeds the captured target, so the increment cannot wrap.
  assign cnt_next = cnt + CNT_W'(1);

  // Fibonacci step: shift left, parity of tapped bits enters at the bottom.
  assign fib_next = {num[WIDTH-2:0], ^(num & taps_q)};

`ifdef LFSR_GALOIS_MODE_EN
  logic             mode_q;
  logic [WIDTH-1:0] galois_next;

  // Galois step: rotate left, fold taps in when the outgoing msb is set.
  assign galois_next = {num[WIDTH-2:0], num[WIDTH-1]} ^
                       (num[WIDTH-1] ? {taps_q[WIDTH-1:1], 1'b0} : '0);
  assign step_next   = mode_q ? galois_next : fib_next;

  // Mode is part of the per-run configuration snapshot.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mode_q <= 1'b0;
    end else if (state == IDLE && start) begin
      mode_q <= mode;
    end
  end
`else
  logic unused_mode;

  // Mode has no effect in a Fibonacci-only build.
  assign unused_mode = mode;
  assign step_next   = fib_next;
`endif

  // Sequencer FSM with registered outputs; config is snapshotted on start.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state  <= IDLE;
      taps_q <= '0;
      seed_q <= '0;
      seq_q  <= '0;
      cnt    <= '0;
      num    <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      valid <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            taps_q <= taps;
            seed_q <= seed;
            seq_q  <= seq_num;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          num <= seed_q;
          cnt <= '0;
          err <= 1'b0;
          if (seed_q == '0) begin
            // All-zero state would lock up the register: flag and skip the run.
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else if (seq_q == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          num   <= step_next;
          cnt   <= cnt_next;
          valid <= 1'b1;
          if (cnt_next == seq_q) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_seq_gen.sv
// tb_lfsr_seq_gen: directed and randomized runs of lfsr_seq_gen (WIDTH=8)
// checked against an arithmetic model of the LFSR step rules.
module tb_lfsr_seq_gen;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 16;

`ifdef LFSR_GALOIS_MODE_EN
  localparam bit GAL = 1'b1;
`else
  localparam bit GAL = 1'b0;
`endif

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          start    = 1'b0;
  logic [W-1:0]  taps     = '0;
  logic [W-1:0]  seed     = '0;
  logic [CW-1:0] seq_num  = '0;
  logic          mode     = 1'b0;
  logic [W-1:0]  num;
  logic          valid;
  logic          busy;
  logic          done;
  logic          err;

  int vectors     = 0;
  int miscompares = 0;

  lfsr_seq_gen #(.WIDTH(W), .CNT_W(CW)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .start    (start),
    .taps     (taps),
    .seed     (seed),
    .seq_num  (seq_num),
    .mode     (mode),
    .num      (num),
    .valid    (valid),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: Fibonacci = multiply by 2, parity of tapped bits as new lsb;
  // Galois = polynomial multiply by x, reduce by x^8 + taps(bits 7..1) + 1.
  function automatic logic [7:0] ref_step(input logic [7:0] v, input logic [7:0] t, input bit m);
    int x;
    x = int'(v);
    if (GAL && m) begin
      x = x * 2;
      if (x >= 256) x = x ^ (256 | int'(t & 8'hFE) | 1);
    end else begin
      x = ((x * 2) % 256) + ($countones(v & t) % 2);
    end
    return 8'(x);
  endfunction

  task automatic run_case(input string tag, input logic [7:0] t, input logic [7:0] s,
                          input logic [15:0] n, input bit m, input bit poke, input bit nolock);
    logic [7:0] exp_q[$];
    logic [7:0] v;
    int         lat;
    int         k;
    int         cyc;
    int         nvalid;
    bit         seen;
    bit         zs;
    zs = (s == 8'h00);
    v  = s;
    if (!zs) begin
      for (int i = 0; i < int'(n); i++) begin
        v = ref_step(v, t, m);
        exp_q.push_back(v);
      end
    end
    lat    = (zs || n == 16'd0) ? 2 : int'(n) + 2;
    nvalid = zs ? 0 : int'(n);

    @(negedge clk);
    taps = t; seed = s; seq_num = n; mode = m; start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    taps    = 8'($urandom);
    seed    = 8'($urandom);
    seq_num = 16'($urandom);
    mode    = 1'($urandom);
    cyc  = 1;
    k    = 0;
    seen = 1'b0;
    while (cyc <= lat + 5 && !seen) begin
      check({tag, ":busy"}, 32'(busy), 32'(cyc < lat));
      check({tag, ":done"}, 32'(done), 32'(cyc == lat));
      if (valid) begin
        if (k < exp_q.size()) begin
          check({tag, ":num"}, 32'(num), 32'(exp_q[k]));
          if (nolock && k < nvalid - 1)
            check({tag, ":lockfree"}, 32'(num == 8'h01 || num == 8'h00), 32'(0));
        end else begin
          check({tag, ":extra_valid"}, 32'(valid), 32'(0));
        end
        k++;
      end
      if (done) seen = 1'b1;
      if (poke && cyc == 3) start = 1'b1;
      if (poke && cyc == 4) start = 1'b0;
      if (!seen) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    check({tag, ":done_seen"}, 32'(seen), 32'(1));
    check({tag, ":latency"}, 32'(cyc), 32'(lat));
    check({tag, ":valid_count"}, 32'(k), 32'(nvalid));
    check({tag, ":final_num"}, 32'(num), 32'(v));
    check({tag, ":err"}, 32'(err), 32'(zs));
    @(negedge clk);
    check({tag, ":done_clear"}, 32'(done), 32'(0));
    check({tag, ":idle_busy"}, 32'(busy), 32'(0));
    check({tag, ":num_hold"}, 32'(num), 32'(v));
    check({tag, ":err_hold"}, 32'(err), 32'(zs));
  endtask

  initial begin
    logic [7:0]  rt;
    logic [7:0]  rs;
    logic [15:0] rn;
    bit          rm;

    // Power-on reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst:num", 32'(num), 32'(0));
    check("rst:valid", 32'(valid), 32'(0));
    check("rst:busy", 32'(busy), 32'(0));
    check("rst:done", 32'(done), 32'(0));
    check("rst:err", 32'(err), 32'(0));
    rst = 1'b0;

    // Directed runs
    run_case("fib5", 8'hB8, 8'h01, 16'd5, 1'b0, 1'b0, 1'b0);
    run_case("fib255", 8'hB8, 8'h01, 16'd255, 1'b0, 1'b0, 1'b1);
    check("fib255:wrap_to_seed", 32'(num), 32'(8'h01));
    run_case("gal1", 8'hB8, 8'h80, 16'd1, 1'b1, 1'b0, 1'b0);
    check("gal1:const", 32'(num), GAL ? 32'(8'hB9) : 32'(8'h01));
    run_case("zero_seed", 8'hB8, 8'h00, 16'd10, 1'b0, 1'b0, 1'b0);
    run_case("zero_len", 8'hB8, 8'h5A, 16'd0, 1'b0, 1'b0, 1'b0);
    run_case("poke_run", 8'h8E, 8'h3C, 16'd12, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a run
    @(negedge clk);
    taps = 8'hB8; seed = 8'h01; seq_num = 16'd20; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst:num", 32'(num), 32'(0));
    check("midrst:valid", 32'(valid), 32'(0));
    check("midrst:busy", 32'(busy), 32'(0));
    check("midrst:done", 32'(done), 32'(0));
    check("midrst:err", 32'(err), 32'(0));
    @(negedge clk);
    check("midrst:idle", 32'(busy), 32'(0));
    run_case("after_rst", 8'hB8, 8'h01, 16'd20, 1'b0, 1'b0, 1'b0);

    // Randomized runs
    for (int r = 0; r < 10; r++) begin
      rt = 8'($urandom);
      rs = 8'($urandom);
      rn = 16'($urandom_range(0, 30));
      rm = 1'($urandom);
      run_case("rand", rt, rs, rn, rm, 1'($urandom), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
